// File: rtl/matrix_pkg.sv
// matrix_pkg
//   Shared definitions for the matrix operand buffer:
//   - default matrix geometry and element width
//   - bank-state encoding (EMPTY / FILLING / FULL)
//   - elem_lsb(): bit offset of element (r,c) in a row-major flat vector
package matrix_pkg;

  localparam int unsigned DEF_ROWS   = 4;
  localparam int unsigned DEF_COLS   = 4;
  localparam int unsigned DEF_DATA_W = 32;

  localparam logic [1:0] BANK_EMPTY   = 2'd0;
  localparam logic [1:0] BANK_FILLING = 2'd1;
  localparam logic [1:0] BANK_FULL    = 2'd2;

  // With data_w = 1 this yields the row-major element index.
  function automatic int unsigned elem_lsb(input int unsigned r,
                                           input int unsigned c,
                                           input int unsigned cols,
                                           input int unsigned data_w);
    return (r * cols + c) * data_w;
  endfunction

endpackage

// File: rtl/matrix_bank.sv
// matrix_bank
//   One N x DATA_W register array holding a single matrix.
//   Ports:
//     clk, reset  - clock, asynchronous active-high reset (zeroes contents)
//     wr_en       - write wr_data into element wr_idx on the rising edge
//     wr_idx      - row-major element index
//     wr_data     - element value
//     rd_data     - all elements, element i at [(i+1)*DATA_W-1 -: DATA_W]
module matrix_bank
  import matrix_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IDX_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [N*DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_rd
    assign rd_data[i*DATA_W +: DATA_W] = mem[i];
  end

endmodule

// File: rtl/matrix_operand_buffer.sv
// matrix_operand_buffer
//   Double-buffered operand store. Words arrive over a valid/ready stream and
//   are placed row-major or column-major into one of two ping-pong banks; the
//   presented bank is exposed as one flat vector.
//   Ports:
//     clk, reset    - clock, asynchronous active-high reset
//     clear         - synchronous flush of counter, pointers, mode, bank states
//     in_valid/in_ready/in_data - element input stream
//     in_col_major  - fill order, sampled with the first word of a matrix
//     out_valid/out_ready       - matrix handshake
//     out_matrix    - element (r,c) at [(r*COLS+c+1)*DATA_W-1 -: DATA_W]
//     busy          - a matrix is partially loaded
module matrix_operand_buffer
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_col_major,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ROWS*COLS*DATA_W-1:0]   out_matrix,
  output logic                          busy
);

  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  logic [CNT_W-1:0]      cnt;
  logic                  wr_bank;
  logic                  rd_bank;
  logic                  mode;
  logic [1:0]            bank_state [2];
  logic [N*DATA_W-1:0]   bank_data  [2];

  logic                  accept;
  logic                  drain;
  logic                  last;
  logic                  eff_mode;
  logic [CNT_W-1:0]      wr_idx;
  int unsigned           wr_pos;

  // in_ready depends only on registered bank state, never on out_ready.
  assign in_ready   = (bank_state[wr_bank] != BANK_FULL);
  assign out_valid  = (bank_state[rd_bank] == BANK_FULL);
  assign out_matrix = bank_data[rd_bank];
  assign busy       = (cnt != '0);

  assign accept   = in_valid && in_ready && !clear;
  assign drain    = out_valid && out_ready && !clear;
  assign last     = (int'(cnt) == int'(N) - 1);
  // The first word of a matrix uses the live fill-order input; later words
  // use the value latched with that first word.
  assign eff_mode = (cnt == '0) ? in_col_major : mode;

  always_comb begin
    wr_pos = int'(cnt);
    if (eff_mode) begin
      wr_pos = elem_lsb(int'(cnt) % ROWS, int'(cnt) / ROWS, COLS, 1);
    end
    wr_idx = CNT_W'(wr_pos);
  end

  // A bank being filled is never FULL and the presented bank is always FULL,
  // so completion of one bank and drain of the other never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      mode          <= 1'b0;
      bank_state[0] <= BANK_EMPTY;
      bank_state[1] <= BANK_EMPTY;
    end else if (clear) begin
      cnt           <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      mode          <= 1'b0;
      bank_state[0] <= BANK_EMPTY;
      bank_state[1] <= BANK_EMPTY;
    end else begin
      if (accept) begin
        if (cnt == '0) begin
          mode <= in_col_major;
        end
        if (last) begin
          cnt                 <= '0;
          bank_state[wr_bank] <= BANK_FULL;
          wr_bank             <= ~wr_bank;
        end else begin
          cnt                 <= cnt + CNT_W'(1);
          bank_state[wr_bank] <= BANK_FILLING;
        end
      end
      if (drain) begin
        bank_state[rd_bank] <= BANK_EMPTY;
        rd_bank             <= ~rd_bank;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    matrix_bank #(
      .N      (N),
      .DATA_W (DATA_W),
      .IDX_W  (CNT_W)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (accept && (wr_bank == 1'(b))),
      .wr_idx  (wr_idx),
      .wr_data (in_data),
      .rd_data (bank_data[b])
    );
  end

endmodule

// File: doc/matrix_operand_buffer.md
# matrix_operand_buffer

Double-buffered operand store for the matrix engine. It accepts a matrix as a stream of `DATA_W`-bit words over a valid/ready handshake and places each word into a `ROWS`×`COLS` bank in row-major or column-major order. It presents each completed matrix as one flat vector to the compute array. Two banks ping-pong, so the next matrix can load while the array still holds the previous one.

## Interface
- `ROWS`, default 4: matrix rows, ≥1.
- `COLS`, default 4: matrix columns, ≥1.
- `DATA_W`, default 32: element width.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `clear`  in  1  synchronous flush of load and bank state.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the buffer can accept a word.
- `in_data`  in  `DATA_W`  matrix element word.
- `in_col_major`  in  1  fill order; sampled with the first word of each matrix.
- `out_valid`  out  1  `out_matrix` holds a complete matrix.
- `out_ready`  in  1  the consumer takes the matrix.
- `out_matrix`  out  `ROWS*COLS*DATA_W`  element (r,c) at bits `[(r*COLS+c+1)*DATA_W-1 -: DATA_W]`.
- `busy`  out  1  a matrix is partially loaded.

## Operation
- N = `ROWS*COLS`. Two banks, 0 and 1, each N×`DATA_W`.
- Pointers and counter:
  - `wr_bank` selects the bank being filled.
  - `rd_bank` selects the bank being presented.
  - `cnt`, 0..N-1, is the word index within the current matrix.
- Each bank has a state machine:
  - EMPTY→FILLING on the first accepted word.
  - FILLING→FULL on the N-th accepted word.
  - FULL→EMPTY on an output handshake.
- Input accept: `in_ready` = 1 when the bank at `wr_bank` is not FULL. A word is accepted when `in_valid && in_ready`.
- On accept:
  - When `cnt`=0, latch `in_col_major` into `mode`; it holds for the whole matrix.
  - Row-major (`mode`=0): word k goes to r=k/`COLS`, c=k%`COLS`.
  - Column-major (`mode`=1): word k goes to c=k/`ROWS`, r=k%`ROWS`.
  - `cnt` increments. At k=N-1, `cnt` wraps to 0, the bank becomes FULL and `wr_bank` toggles.
- Output:
  - `out_valid` = bank at `rd_bank` is FULL.
  - `out_matrix` = contents of bank `rd_bank`, driven combinationally whether or not `out_valid` is high.
  - On `out_valid && out_ready`, that bank becomes EMPTY and `rd_bank` toggles. The bank contents are not cleared.
- `busy` = (`cnt` ≠ 0). It is low between matrices, including when both banks are FULL.
- `clear`:
  - Sets `cnt`, `wr_bank`, `rd_bank` and `mode` to 0 and both banks to EMPTY.
  - Leaves bank contents as they are.
  - Overrides any handshake in the same cycle; that word and any pending matrix are discarded.
- Reset values: all banks zeroed, `cnt`=0, both pointers 0, both banks EMPTY. Outputs after reset: `in_ready`=1, `out_valid`=0, `busy`=0, `out_matrix`=0.
- N=1: every accepted word completes a matrix, and `busy` stays 0.

## Timing
- Write latency: a word accepted at edge t appears in `out_matrix` once its bank is presented.
- Out-valid latency: the N-th word accepted at edge t gives `out_valid`=1 after edge t (zero-bubble).
- Throughput:
  - 1 word/cycle sustained while the consumer drains within N cycles.
  - No dead cycle between matrices.
  - `in_ready` falls only when both banks are FULL.
- Both banks FULL with `out_ready`=1: `rd_bank` is freed at edge t, and `in_ready`=1 in the following cycle. `in_ready` does not depend combinationally on `out_ready`.
- Same-cycle completion of bank X and drain of bank Y ≠ X: both take effect at the same edge.
- Reset mid-load: the partial matrix is lost, and the next accepted word has k=0.
- `out_valid` stays high, with `out_matrix` stable, until a handshake occurs.

## Structure
- Shared package `matrix_pkg`:
  - `ROWS`/`COLS`/`DATA_W` defaults.
  - The bank-state encoding EMPTY/FILLING/FULL.
  - The element bit-offset function `elem_lsb(r,c)`.
- Sub-module `matrix_bank`:
  - One N×`DATA_W` register array with write enable, write index and flat read-out.
  - Instantiated twice.
  - Index calculation and the handshake state machine stay in the top level.

## Test plan
- Reset, then 16 words 1..16 in row-major with `out_ready`=0:
  - `out_valid` rises after the 16th edge.
  - Element (1,2) = 7.
  - `busy` is high for words 2..16 and low after the last.
- 16 words 1..16 with `in_col_major`=1 on the first word only:
  - Element (1,2) = 10.
  - Element (3,0) = 4.
- Continuous 48-word stream with `out_ready`=1: three matrices emitted back-to-back, `in_ready` never drops.
- `out_ready`=0 while 32 words arrive:
  - `in_ready`=0 after the 32nd.
  - One handshake restores `in_ready`=1 in the next cycle.
  - The second matrix is intact.
- Reset after 5 words, then 16 words 100..115: the first matrix is 100..115, and `busy` behaves as for a fresh load.
- `clear` asserted with `in_valid`=1 at `cnt`=9: that word is dropped, `cnt`=0, and `out_valid`=0.
